// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters, each with a one-deep result slot.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index fixed priority; default build is round-robin.
package rv32i_types;
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;
endpackage

module alu_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_valid_i,
  output logic [NREQ-1:0]  req_ready_o,
  input  alu_ops           req_aluop_i [NREQ],
  input  logic [31:0]      req_a_i [NREQ],
  input  logic [31:0]      req_b_i [NREQ],
  output logic [NREQ-1:0]  resp_valid_o,
  input  logic [NREQ-1:0]  resp_ready_i,
  output logic [31:0]      resp_f_o [NREQ],
  output alu_ops           alu_op_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  input  logic [31:0]      alu_f_i,
  output logic [15:0]      conflict_cnt_o
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0] elig_s;
  logic [NREQ-1:0] gnt_s;
  logic [NREQ-1:0] accept_s;
  logic [IW-1:0]   gnt_idx_s;
  logic            gnt_found_s;

  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_f_q [NREQ];
  logic [31:0]     resp_f_d [NREQ];
  logic [15:0]     conflict_cnt_q, conflict_cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   last_grant_q, last_grant_d;
`endif

  // A slot that is full and not draining this cycle cannot take a new result.
  assign elig_s = req_valid_i & (~resp_valid_q | resp_ready_i);

  // Priority search; later iterations override earlier ones, so the last candidate checked wins.
  always_comb begin
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig_s[k]) begin
        gnt_idx_s   = IW'(k);
        gnt_found_s = 1'b1;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      logic [31:0] cand;
      cand = (32'(last_grant_q) + 32'(k)) % NREQ;
      if (elig_s[cand]) begin
        gnt_idx_s   = IW'(cand);
        gnt_found_s = 1'b1;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
`endif
  end

  // Grant and shared-ALU operand mux; idle or in-reset cycles present add 0+0.
  always_comb begin
    gnt_s    = '0;
    alu_op_o = alu_add;
    alu_a_o  = 32'h0000_0000;
    alu_b_o  = 32'h0000_0000;
    if (rst_ni && gnt_found_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
      alu_op_o         = req_aluop_i[gnt_idx_s];
      alu_a_o          = req_a_i[gnt_idx_s];
      alu_b_o          = req_b_i[gnt_idx_s];
    end else begin
      gnt_s = '0;
    end
  end

  assign req_ready_o = gnt_s;
  assign accept_s    = gnt_s & req_valid_i;

  // Next state: per-slot capture/drain/hold, saturating contention counter, rotation pointer.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      resp_valid_d[i] = resp_valid_q[i];
      resp_f_d[i]     = resp_f_q[i];
      if (accept_s[i]) begin
        resp_valid_d[i] = 1'b1;
        resp_f_d[i]     = alu_f_i;
      end else if (resp_ready_i[i]) begin
        resp_valid_d[i] = 1'b0;
      end else begin
        resp_valid_d[i] = resp_valid_q[i];
      end
    end
    if (($countones(elig_s) > 32'sd1) && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
`ifndef ALU_ARB_FIXED_PRIO_EN
    if (|accept_s) begin
      last_grant_d = gnt_idx_s;
    end else begin
      last_grant_d = last_grant_q;
    end
`endif
  end

  // State registers with synchronous active-low reset; reset drops undelivered results.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_valid_q   <= '0;
      conflict_cnt_q <= 16'h0000;
      for (int i = 0; i < NREQ; i++) begin
        resp_f_q[i] <= 32'h0000_0000;
      end
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q   <= IW'(NREQ - 1);
`endif
    end else begin
      resp_valid_q   <= resp_valid_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int i = 0; i < NREQ; i++) begin
        resp_f_q[i] <= resp_f_d[i];
      end
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_f_o       = resp_f_q;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NREQ=2) with a reference ALU on the shared port.
module tb_alu_arbiter;
  import rv32i_types::*;

  localparam int unsigned NREQ = 2;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  alu_ops          req_aluop [NREQ];
  logic [31:0]     req_a [NREQ];
  logic [31:0]     req_b [NREQ];
  logic [1:0]      resp_valid;
  logic [1:0]      resp_ready;
  logic [31:0]     resp_f [NREQ];
  alu_ops          alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_f;
  logic [15:0]     conflict_cnt;

  int checks;
  int errors;
  logic [1:0] exp_gnt [4];

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_aluop_i    (req_aluop),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_f_o       (resp_f),
    .alu_op_o       (alu_op),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_f_i        (alu_f),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU instance.
  always_comb begin
    case (alu_op)
      alu_add: alu_f = alu_a + alu_b;
      alu_sll: alu_f = alu_a << alu_b[4:0];
      alu_sra: alu_f = 32'($signed(alu_a) >>> alu_b[4:0]);
      alu_sub: alu_f = alu_a - alu_b;
      alu_xor: alu_f = alu_a ^ alu_b;
      alu_srl: alu_f = alu_a >> alu_b[4:0];
      alu_or:  alu_f = alu_a | alu_b;
      alu_and: alu_f = alu_a & alu_b;
      default: alu_f = 32'h0000_0000;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`else
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
`endif
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      req_aluop[i] = alu_add;
      req_a[i]     = 32'h0000_0001;
      req_b[i]     = 32'h0000_0001;
    end
    tick();
    tick();
    // Reset state, with requests pending during reset
    check_eq("rst_ready",    32'(req_ready), 32'h0);
    check_eq("rst_valid",    32'(resp_valid), 32'h0);
    check_eq("rst_f0",       resp_f[0], 32'h0);
    check_eq("rst_conflict", 32'(conflict_cnt), 32'h0);
    check_eq("rst_alu_a",    alu_a, 32'h0);

    // Single request: 5 + 7
    rst_n        = 1'b1;
    req_valid    = 2'b01;
    req_aluop[0] = alu_add;
    req_a[0]     = 32'd5;
    req_b[0]     = 32'd7;
    resp_ready   = 2'b01;
    #1;
    check_eq("single_ready", 32'(req_ready), 32'h1);
    check_eq("single_op",    32'(alu_op), 32'(alu_add));
    check_eq("single_a",     alu_a, 32'd5);
    check_eq("single_b",     alu_b, 32'd7);
    tick();
    req_valid = 2'b00;
    check_eq("single_valid", 32'(resp_valid), 32'h1);
    check_eq("single_f0",    resp_f[0], 32'd12);
    #1;
    check_eq("idle_alu_a",   alu_a, 32'h0);
    check_eq("idle_alu_op",  32'(alu_op), 32'(alu_add));
    tick();
    check_eq("single_drain", 32'(resp_valid), 32'h0);
    check_eq("single_hold",  resp_f[0], 32'd12);

    // Contention from reset state
    do_reset();
    req_valid    = 2'b11;
    resp_ready   = 2'b11;
    req_aluop[0] = alu_add; req_a[0] = 32'd1; req_b[0] = 32'd1;
    req_aluop[1] = alu_add; req_a[1] = 32'd2; req_b[1] = 32'd2;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("contend_gnt%0d", c), 32'(req_ready), 32'(exp_gnt[c]));
      tick();
    end
    check_eq("contend_cnt", 32'(conflict_cnt), 32'd4);
    check_eq("contend_f0",  resp_f[0], 32'd2);

    // Backpressure on requester 0
    do_reset();
    req_valid    = 2'b01;
    resp_ready   = 2'b00;
    req_aluop[0] = alu_sra; req_a[0] = 32'h8000_0000; req_b[0] = 32'd4;
    #1;
    check_eq("bp_ready0", 32'(req_ready), 32'h1);
    tick();
    check_eq("bp_f0", resp_f[0], 32'hF800_0000);
    req_valid    = 2'b11;
    req_aluop[1] = alu_sub; req_a[1] = 32'd3; req_b[1] = 32'd5;
    #1;
    check_eq("bp_ready1", 32'(req_ready), 32'h2);
    check_eq("bp_op1",    32'(alu_op), 32'(alu_sub));
    tick();
    check_eq("bp_f1",       resp_f[1], 32'hFFFF_FFFE);
    check_eq("bp_f0_hold",  resp_f[0], 32'hF800_0000);
    check_eq("bp_valid",    32'(resp_valid), 32'h3);
    check_eq("bp_conflict", 32'(conflict_cnt), 32'h0);
    req_valid = 2'b01;
    #1;
    check_eq("bp_none", 32'(req_ready), 32'h0);
    tick();
    check_eq("bp_f0_hold2", resp_f[0], 32'hF800_0000);

    // Drain and accept on requester 0 in the same cycle
    req_valid    = 2'b01;
    resp_ready   = 2'b01;
    req_aluop[0] = alu_xor; req_a[0] = 32'h0000_00FF; req_b[0] = 32'h0000_000F;
    #1;
    check_eq("da_ready", 32'(req_ready), 32'h1);
    tick();
    check_eq("da_valid",   32'(resp_valid), 32'h3);
    check_eq("da_f0",      resp_f[0], 32'h0000_00F0);
    check_eq("da_f1_hold", resp_f[1], 32'hFFFF_FFFE);
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    tick();
    check_eq("drain_all", 32'(resp_valid), 32'h0);
    tick();
    check_eq("drain_idle",    32'(resp_valid), 32'h0);
    check_eq("drain_f0_keep", resp_f[0], 32'h0000_00F0);

    // Reset one cycle after an accept
    req_valid    = 2'b11;
    resp_ready   = 2'b00;
    req_aluop[0] = alu_add; req_a[0] = 32'd1;  req_b[0] = 32'd1;
    req_aluop[1] = alu_add; req_a[1] = 32'd10; req_b[1] = 32'd20;
    tick();
    check_eq("mid_conflict", 32'(conflict_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check_eq("mid_valid",    32'(resp_valid), 32'h0);
    check_eq("mid_f0",       resp_f[0], 32'h0);
    check_eq("mid_f1",       resp_f[1], 32'h0);
    check_eq("mid_conflict0", 32'(conflict_cnt), 32'h0);
    rst_n      = 1'b1;
    resp_ready = 2'b11;
    #1;
    check_eq("post_rst_gnt", 32'(req_ready), 32'h1);
    check_eq("post_rst_a",   alu_a, 32'd1);
    tick();

    // Saturation of the contention counter
    do_reset();
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    repeat (65534) tick();
    check_eq("sat_fffe", 32'(conflict_cnt), 32'h0000_FFFE);
    tick();
    check_eq("sat_ffff", 32'(conflict_cnt), 32'h0000_FFFF);
    tick();
    tick();
    check_eq("sat_hold", 32'(conflict_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters sharing one alu instance (legal 2..4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset asserted, sampled on rising clk).
REQ-004 req_valid  input  NREQ  requester i presents an operation.
REQ-005 req_ready  output  NREQ  grant; operation i accepted when req_valid[i] and req_ready[i] both 1.
REQ-006 req_aluop  input  NREQ x alu_ops  operation select per requester (rv32i_types).
REQ-007 req_a, req_b  input  NREQ x 32  operands per requester.
REQ-008 resp_valid  output  NREQ  result slot i holds an undelivered result.
REQ-009 resp_ready  input  NREQ  requester i consumes resp_f[i] this cycle.
REQ-010 resp_f  output  NREQ x 32  registered result per requester.
REQ-011 alu_op, alu_a, alu_b  output  alu_ops, 32, 32  drive to the shared alu instance.
REQ-012 alu_f  input  32  combinational result from the shared alu.
REQ-013 conflict_cnt  output  16  count of cycles with more than one eligible requester.

Function
REQ-014 Requester i is eligible when req_valid[i]=1 and (resp_valid[i]=0 or resp_ready[i]=1).
REQ-015 At most one req_ready bit is 1 per cycle; req_ready is combinational from eligibility and priority state.
REQ-016 Default priority is round-robin: search starts at index (last_grant+1) mod NREQ; last_grant updates only on an accepted operation.
REQ-017 A non-eligible requester is never granted, even if next in rotation.
REQ-018 On grant to i, alu_op/alu_a/alu_b equal req_aluop[i]/req_a[i]/req_b[i] in the same cycle.
REQ-019 With no grant, alu_op = alu_add, alu_a = 0, alu_b = 0.
REQ-020 On accept of i, alu_f is captured into resp_f[i] and resp_valid[i]=1 from the next cycle (latency 1 cycle).
REQ-021 resp_f[i] and resp_valid[i] hold unchanged while resp_valid[i]=1 and resp_ready[i]=0.
REQ-022 resp_ready[i]=1 with no new accept for i clears resp_valid[i] next cycle; resp_f[i] holds last value.
REQ-023 Simultaneous drain and accept on i: resp_valid[i] stays 1, resp_f[i] takes new result (back-to-back throughput 1/cycle per requester when alone).
REQ-024 resp_ready[i] while resp_valid[i]=0 has no effect.
REQ-025 Each requester has at most one outstanding result; slots are independent.
REQ-026 conflict_cnt increments by 1 in each cycle with two or more eligible requesters; saturates at 0xFFFF.

Reset
REQ-027 While rst=0 at a rising edge: resp_valid = 0, resp_f = 0, conflict_cnt = 0, last_grant = NREQ-1 (requester 0 has first priority).
REQ-028 req_ready = 0 in any cycle where rst=0; reset mid-operation discards all pending results without delivery.
REQ-029 First grant possible in the first cycle with rst=1.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest-index eligible requester wins; last_grant unused; REQ-016 does not apply.
REQ-031 Macro undefined: round-robin per REQ-016; all other requirements identical in both builds.

Verification
REQ-032 Single req: NREQ=2, req0 alu_add a=5 b=7, resp_ready0=1 -> req_ready0=1 same cycle, resp_valid0=1 with resp_f0=12 next cycle, then 0.
REQ-033 Contention round-robin: both valid continuously, resp_ready=11 -> grants alternate 0,1,0,1; conflict_cnt=4 after 4 cycles; with ALU_ARB_FIXED_PRIO_EN grants 0,0,0,0.
REQ-034 Backpressure: req0 alu_sra a=0x80000000 b=4, resp_ready0=0 -> resp_f0=0xF8000000 held; req0 ineligible, req1 (alu_sub 3-5) granted, resp_f1=0xFFFFFFFE.
REQ-035 Drain+accept: resp_valid0=1, resp_ready0=1, req0 alu_xor 0xFF^0x0F same cycle -> resp_valid0 stays 1, resp_f0=0xF0.
REQ-036 Reset mid-op: rst=0 the cycle after an accept -> resp_valid=0, resp_f=0, conflict_cnt=0; after release, requester 0 wins first contended cycle.
REQ-037 Saturation: force 0x10000 contended cycles -> conflict_cnt stays 0xFFFF.
